// File: rtl/pin_chain_tester.sv
// Pin-chain loopback tester: walking-one then walking-zero over N_PINS, 2N*(SETTLE_CYCLES+1)+1 cycles to done; no backpressure.
// Define PIN_CHAIN_ERRMAP_EN to add err_map, the OR of every per-step mismatch vector in a run.
module pin_chain_tester #(
  parameter int N_PINS        = 17,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            high_z_req,
  input  logic [N_PINS-1:0]               pin_in,
  output logic [N_PINS-1:0]               pin_out,
  output logic                            pin_oe,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [ERR_W-1:0]                err_count,
  output logic [$clog2(2*N_PINS)-1:0]     first_step,
`ifdef PIN_CHAIN_ERRMAP_EN
  output logic [N_PINS-1:0]               first_mask,
  output logic [N_PINS-1:0]               err_map
`else
  output logic [N_PINS-1:0]               first_mask
`endif
);

  localparam int STEP_W = $clog2(2*N_PINS);
  localparam int CNT_W  = $clog2(SETTLE_CYCLES);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*N_PINS-1);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(SETTLE_CYCLES-1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_PINS-1:0]   sync1_q, sync2_q;
  logic [N_PINS-1:0]   pin_out_q;
  logic                busy_q, done_q, pass_q;
  logic [ERR_W-1:0]    err_q;
  logic [STEP_W-1:0]   first_step_q;
  logic [N_PINS-1:0]   first_mask_q;
  logic [N_PINS-1:0]   diff;
  logic                accept;
  logic                sample_en;

  function automatic logic [N_PINS-1:0] pattern(input logic [STEP_W-1:0] s);
    logic [N_PINS-1:0] one;
    one = N_PINS'(1);
    if (s < STEP_W'(N_PINS)) pattern = one << s;
    else                     pattern = ~(one << (s - STEP_W'(N_PINS)));
  endfunction

  assign pin_oe     = !high_z_req;
  assign pin_out    = pin_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_step = first_step_q;
  assign first_mask = first_mask_q;

  assign diff      = sync2_q ^ pattern(step_q);
  assign accept    = (state_q == IDLE || state_q == DONE) && start && !high_z_req;
  assign sample_en = (state_q == SAMPLE) && !high_z_req;

  // pin_in is fully asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      cnt_q        <= '0;
      pin_out_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_step_q <= '0;
      first_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          pin_out_q <= '0;
          // done/pass register one cycle after entry so pass sees the final count.
          if (state_q == DONE) begin
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
          end
          if (accept) begin
            state_q      <= SETTLE;
            step_q       <= '0;
            cnt_q        <= CNT_INIT;
            pin_out_q    <= pattern('0);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_step_q <= '0;
            first_mask_q <= '0;
          end
        end
        SETTLE, SAMPLE: begin
          if (high_z_req) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            pin_out_q <= '0;
          end else if (state_q == SETTLE) begin
            if (cnt_q == '0) state_q <= SAMPLE;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end else begin
            if (diff != '0) begin
              if (err_q != ERR_MAX) err_q <= err_q + ERR_W'(1);
              // err_q never returns to zero within a run, so it marks the first failure.
              if (err_q == '0) begin
                first_step_q <= step_q;
                first_mask_q <= diff;
              end
            end
            if (step_q == LAST_STEP) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              pin_out_q <= '0;
            end else begin
              step_q    <= step_q + STEP_W'(1);
              pin_out_q <= pattern(step_q + STEP_W'(1));
              cnt_q     <= CNT_INIT;
              state_q   <= SETTLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PIN_CHAIN_ERRMAP_EN
  logic [N_PINS-1:0] err_map_q;

  assign err_map = err_map_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_map_q <= '0;
    else if (accept)    err_map_q <= '0;
    else if (sample_en) err_map_q <= err_map_q | diff;
  end
`endif

endmodule

// File: tb/tb_pin_chain_tester.sv
// Directed bench for pin_chain_tester: ideal, stuck, swapped, saturating, abort and reset runs.
module tb_pin_chain_tester;

  logic        clk = 1'b0;
  logic        rst_n;
  int          mode;
  int          n_assert = 0;
  int          n_fail   = 0;

  logic        start_a, hz_a;
  logic [16:0] pin_in_a, pin_out_a, fmask_a;
  logic        oe_a, busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [5:0]  fstep_a;

  logic        start_b, hz_b;
  logic [7:0]  pin_in_b, pin_out_b, fmask_b;
  logic        oe_b, busy_b, done_b, pass_b;
  logic [3:0]  err_b;
  logic [3:0]  fstep_b;

`ifdef PIN_CHAIN_ERRMAP_EN
  logic [16:0] map_a;
  logic [7:0]  map_b;
`endif

  always #5 clk = ~clk;

  // Board loopback model: 0 ideal, 1 pin 5 stuck low, 2 pins 0 and 1 swapped.
  assign pin_in_a = (mode == 1) ? (pin_out_a & ~17'h00020) :
                    (mode == 2) ? {pin_out_a[16:2], pin_out_a[0], pin_out_a[1]} :
                                  pin_out_a;
  assign pin_in_b = 8'h00;
  assign hz_b     = 1'b0;

  pin_chain_tester dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .high_z_req(hz_a),
    .pin_in(pin_in_a), .pin_out(pin_out_a), .pin_oe(oe_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_step(fstep_a),
`ifdef PIN_CHAIN_ERRMAP_EN
    .first_mask(fmask_a), .err_map(map_a)
`else
    .first_mask(fmask_a)
`endif
  );

  pin_chain_tester #(.N_PINS(8), .SETTLE_CYCLES(4), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .high_z_req(hz_b),
    .pin_in(pin_in_b), .pin_out(pin_out_b), .pin_oe(oe_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_step(fstep_b),
`ifdef PIN_CHAIN_ERRMAP_EN
    .first_mask(fmask_b), .err_map(map_b)
`else
    .first_mask(fmask_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut_a and count cycles until done; optionally re-pulse start mid-run.
  task automatic run_a(input int restart_at, output int cyc,
                       output logic [16:0] p0, output logic [16:0] p85);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    p0  = pin_out_a;
    p85 = '0;
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 400) begin
      if (cyc == restart_at) start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      cyc++;
      if (cyc == 85) p85 = pin_out_a;
    end
  endtask

  initial begin
    int          cyc;
    logic [16:0] p0, p85;

    rst_n   = 1'b0;
    start_a = 1'b0;
    hz_a    = 1'b0;
    start_b = 1'b0;
    mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    busy_a,    0);
    chk("rst_done",    done_a,    0);
    chk("rst_pass",    pass_a,    0);
    chk("rst_err",     err_a,     0);
    chk("rst_fstep",   fstep_a,   0);
    chk("rst_fmask",   fmask_a,   0);
    chk("rst_pin_out", pin_out_a, 0);
    chk("rst_oe",      oe_a,      1);
    chk("rst_oe_b",    oe_b,      1);
    chk("rst_err_b",   err_b,     0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal loopback.
    run_a(-1, cyc, p0, p85);
    chk("ideal_cycles", cyc,       171);
    chk("ideal_s0_out", p0,        32'h00001);
    chk("ideal_s17_out",p85,       32'h1FFFE);
    chk("ideal_pass",   pass_a,    1);
    chk("ideal_err",    err_a,     0);
    chk("ideal_fmask",  fmask_a,   0);
    chk("ideal_busy",   busy_a,    0);
    chk("ideal_pin_out",pin_out_a, 0);
`ifdef PIN_CHAIN_ERRMAP_EN
    chk("ideal_map",    map_a,     0);
`endif

    // Pin 5 stuck low: step 5 plus all 16 walking-zero steps other than step 22.
    mode = 1;
    run_a(-1, cyc, p0, p85);
    chk("stuck_cycles", cyc,     171);
    chk("stuck_err",    err_a,   17);
    chk("stuck_fstep",  fstep_a, 5);
    chk("stuck_fmask",  fmask_a, 32'h00020);
    chk("stuck_pass",   pass_a,  0);
    chk("stuck_done",   done_a,  1);
`ifdef PIN_CHAIN_ERRMAP_EN
    chk("stuck_map",    map_a,   32'h00020);
`endif

    // Pins 0/1 swapped, started straight from DONE.
    mode = 2;
    run_a(-1, cyc, p0, p85);
    chk("swap_err",   err_a,   4);
    chk("swap_fstep", fstep_a, 0);
    chk("swap_fmask", fmask_a, 32'h00003);
    chk("swap_pass",  pass_a,  0);
`ifdef PIN_CHAIN_ERRMAP_EN
    chk("swap_map",   map_a,   32'h00003);
`endif

    // 8-pin instance, everything stuck low: 16 failures saturate a 4-bit counter.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("small_cycles", cyc,     81);
    chk("small_err",    err_b,   15);
    chk("small_fstep",  fstep_b, 0);
    chk("small_fmask",  fmask_b, 32'h01);
    chk("small_pass",   pass_b,  0);
`ifdef PIN_CHAIN_ERRMAP_EN
    chk("small_map",    map_b,   32'hFF);
`endif

    // Abort by high_z_req at cycle 40, with pin 5 stuck so partial results are visible.
    mode = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    hz_a = 1'b1;
    #1;
    chk("hz_oe_now",   oe_a,   0);
    chk("hz_busy_now", busy_a, 1);
    @(posedge clk);
    #1;
    chk("hz_busy",    busy_a,    0);
    chk("hz_done",    done_a,    0);
    chk("hz_pass",    pass_a,    0);
    chk("hz_pin_out", pin_out_a, 0);
    chk("hz_err",     err_a,     1);
    chk("hz_fstep",   fstep_a,   5);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("hz_start_ign_busy", busy_a, 0);
    chk("hz_start_ign_err",  err_a,  1);
    hz_a = 1'b0;
    mode = 0;
    run_a(-1, cyc, p0, p85);
    chk("post_hz_cycles", cyc,    171);
    chk("post_hz_pass",   pass_a, 1);
    chk("post_hz_err",    err_a,  0);
    chk("post_hz_oe",     oe_a,   1);

    // Asynchronous reset mid-run.
    mode = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk("pre_rst_err", err_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    busy_a,    0);
    chk("mid_rst_err",     err_a,     0);
    chk("mid_rst_fstep",   fstep_a,   0);
    chk("mid_rst_fmask",   fmask_a,   0);
    chk("mid_rst_pin_out", pin_out_a, 0);
    chk("mid_rst_done",    done_a,    0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;

    // Start re-pulsed while busy must not restart or stretch the run.
    run_a(30, cyc, p0, p85);
    chk("restart_cycles", cyc,    171);
    chk("restart_pass",   pass_a, 1);
    chk("restart_err",    err_a,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
